// File: rtl/tick_gen_pkg.sv
// Shared defaults and helpers for the multi-channel tick generator.
// Holds counter width, reset divisor and the channel-index width function.
package tick_gen_pkg;

  localparam int CNT_W_DEF = 27;
  localparam int DEFAULT_DIV_DEF = 50_000_000;

  // Width of the channel select bus; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, active/shadow divisor, tick pulse and level.
// Ports: clock, reset, enable, sync_clear, wr, wr_data -> tick, level.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clear,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             tick,
  output logic             level
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_sh;
  logic             pend;

  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] nxt_sh;
  logic             nxt_pend;
  logic             wrap;
  logic             apply;

  // A divisor of zero behaves as one. The wrap test uses >= so a
  // counter held while disabled across a divisor shrink still wraps
  // at once instead of running off to the top of its range.
  always_comb begin
    d_eff    = (div == '0) ? CNT_W'(1) : div;
    wrap     = enable && (cnt >= d_eff - CNT_W'(1));
    nxt_sh   = wr ? wr_data : div_sh;
    nxt_pend = wr | pend;
    apply    = nxt_pend && (wrap || !enable || sync_clear);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      div    <= RST_DIV;
      div_sh <= RST_DIV;
      pend   <= 1'b0;
      tick   <= 1'b0;
      level  <= 1'b0;
    end else begin
      div_sh <= nxt_sh;
      if (apply) begin
        div  <= nxt_sh;
        pend <= 1'b0;
      end else begin
        pend <= nxt_pend;
      end
      if (sync_clear) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (wrap) begin
        cnt   <= '0;
        tick  <= 1'b1;
        level <= ~level;
      end else begin
        tick <= 1'b0;
        if (enable) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multi_tick_generator.sv
// NUM_CH independent clock-enable tick generators with programmable divisors.
// Ports: clock, reset, enable, sync_clear, div_wr/div_sel/div_data -> tick, level.
module multi_tick_generator
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           enable,
  input  logic                        sync_clear,
  input  logic                        div_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0] div_sel,
  input  logic [CNT_W-1:0]            div_data,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           level
);

  logic [NUM_CH-1:0] wr_hit;

  // Selects at or above NUM_CH match no channel and are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = div_wr && (int'(div_sel) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable[g]),
      .sync_clear (sync_clear),
      .wr         (wr_hit[g]),
      .wr_data    (div_data),
      .tick       (tick[g]),
      .level      (level[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Scoreboard bench for multi_tick_generator with two channels, divisor 4.
// Stimulus queues expected ticks; a negedge monitor pops and compares.
module tb_multi_tick_generator;

  localparam int NCH = 2;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NCH-1:0] enable = '0;
  logic          sync_clear = 1'b0;
  logic          div_wr = 1'b0;
  logic [0:0]    div_sel = '0;
  logic [CW-1:0] div_data = '0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] level;

  multi_tick_generator #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sync_clear (sync_clear),
    .div_wr     (div_wr),
    .div_sel    (div_sel),
    .div_data   (div_data),
    .tick       (tick),
    .level      (level)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int lvl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   mlvl[NCH];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int c);
    exp_t e;
    mlvl[ch] = 1 - mlvl[ch];
    e.cyc = c;
    e.lvl = mlvl[ch];
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon_ch(input int ch);
    exp_t e;
    int   sz;
    sz = (ch == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      e = (ch == 0) ? q0[0] : q1[0];
      if (e.cyc < cyc) begin
        chk($sformatf("missed_tick%0d", ch), 0, 1);
        if (ch == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        sz--;
      end
    end
    if (tick[ch]) begin
      if (sz == 0) begin
        chk($sformatf("extra_tick%0d", ch), 1, 0);
      end else begin
        if (ch == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("tick_cycle%0d", ch), cyc, e.cyc);
        chk($sformatf("tick_level%0d", ch), int'(level[ch]), e.lvl);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      for (int ch = 0; ch < NCH; ch++) mon_ch(ch);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic wr(input int sel, input int data);
    div_sel  = 1'(sel);
    div_data = CW'(data);
    div_wr   = 1'b1;
    @(negedge clock);
    div_wr   = 1'b0;
  endtask

  task automatic fast_run(input int data, input int n);
    int t;
    wr(0, data);
    t = cyc;
    enable[0] = 1'b1;
    for (int k = 1; k <= n; k++) push(0, t + k);
    wait_to(t + n);
    enable[0] = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int t;
    int b;
    int r;
    mlvl[0] = 0;
    mlvl[1] = 0;
    repeat (3) @(negedge clock);
    chk("rst_tick", int'(tick), 0);
    chk("rst_level", int'(level), 0);
    reset = 1'b0;

    // Defaults: divisor 4 on both channels.
    t = cyc;
    enable = 2'b11;
    for (int ch = 0; ch < NCH; ch++) begin
      push(ch, t + 4);
      push(ch, t + 8);
      push(ch, t + 12);
    end
    wait_to(t + 12);
    enable = 2'b00;
    @(negedge clock);
    chk("hold_tick", int'(tick), 0);
    chk("hold_level", int'(level), 3);

    // Divisor 0 then 1: tick every cycle.
    fast_run(0, 6);
    fast_run(1, 4);
    wr(0, 4);

    // Reload on ch1: 10 -> 3 without a truncated period.
    wr(1, 10);
    t = cyc;
    enable[1] = 1'b1;
    push(1, t + 10);
    push(1, t + 20);
    push(1, t + 23);
    push(1, t + 26);
    wait_to(t + 12);
    wr(1, 3);
    wait_to(t + 26);
    enable[1] = 1'b0;

    // Out-of-range select does not exist with 2 channels on 1 bit;
    // ch0 runs div 4 with an enable gap at cnt 2.
    b = cyc;
    enable[0] = 1'b1;
    push(0, b + 4);
    push(0, b + 13);
    push(0, b + 17);
    wait_to(b + 6);
    enable[0] = 1'b0;
    wait_to(b + 11);
    enable[0] = 1'b1;
    wait_to(b + 17);

    // sync_clear landing on ch0's wrap cycle.
    wr(1, 4);
    wait_to(b + 20);
    sync_clear = 1'b1;
    enable = 2'b11;
    wait_to(b + 21);
    sync_clear = 1'b0;
    push(0, b + 25);
    push(1, b + 25);
    wait_to(b + 25);

    // Asynchronous reset while ticks are high.
    #2;
    reset = 1'b1;
    #1;
    chk("async_tick", int'(tick), 0);
    chk("async_level", int'(level), 0);
    mlvl[0] = 0;
    mlvl[1] = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    r = cyc;
    push(0, r + 4);
    push(1, r + 4);
    wait_to(r + 6);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
